// File: rtl/lcd_char_ctrl.sv
// Character-display controller: 128-byte HD44780-style display RAM with command/data
// CPU access, busy timing, timed clear sweep and a registered scan port for the driver.
module lcd_char_ctrl #(
  parameter int COLS        = 16,
  parameter int BUSY_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rd,
  input  logic       cmd,
  input  logic [7:0] dbus,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic [6:0] scan_addr,
  output logic [7:0] scan_char
);

  typedef enum logic [1:0] {IDLE, HOLD, CLEAR} state_t;

  // The counter serves both the hold timer and the clear sweep, so it must cover both.
  localparam int CNT_W = (BUSY_CYCLES > 128) ? $clog2(BUSY_CYCLES) : 7;

  localparam logic [6:0]       ROW0_LAST  = 7'(COLS - 1);
  localparam logic [6:0]       ROW1_FIRST = 7'h40;
  localparam logic [6:0]       ROW1_LAST  = 7'(64 + COLS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(127);
  localparam logic [7:0]       BLANK      = 8'h20;
  localparam logic [7:0]       SUBST      = 8'h3F;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       addr_q, addr_d;
  logic             id_q, id_d;
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic             rd_mem;
  logic             rd_status;

  logic [7:0] mem [128];

  // Cursor movement jumps between the visible windows of row 0 and row 1.
  function automatic logic [6:0] advance(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == ROW0_LAST)      return ROW1_FIRST;
      else if (a == ROW1_LAST) return 7'h00;
      else                     return a + 7'd1;
    end else begin
      if (a == 7'h00)           return ROW1_LAST;
      else if (a == ROW1_FIRST) return ROW0_LAST;
      else                      return a - 7'd1;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    id_d      = id_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = dbus;
    rd_mem    = 1'b0;
    rd_status = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[6:0];
        mem_wdata = BLANK;
        if (cnt_q == CLEAR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d = '0;
        if (wr && cmd) begin
          // Commands decode on the most significant set bit of the byte.
          casez (dbus)
            8'b1???????: begin
              addr_d  = dbus[6:0];
              state_d = HOLD;
            end
            8'b01??????, 8'b001?????, 8'b0001????, 8'b00001???: state_d = HOLD;
            8'b000001??: begin
              id_d    = dbus[1];
              state_d = HOLD;
            end
            8'b0000001?: begin
              addr_d  = 7'h00;
              state_d = HOLD;
            end
            8'b00000001: begin
              addr_d  = 7'h00;
              id_d    = 1'b1;
              state_d = CLEAR;
            end
            default: ;
          endcase
        end else if (wr) begin
          mem_we    = 1'b1;
          mem_wdata = ((dbus >= 8'h20) && (dbus <= 8'h7E)) ? dbus : SUBST;
          addr_d    = advance(addr_q, id_q);
          state_d   = HOLD;
        end else if (rd && !cmd) begin
          rd_mem = 1'b1;
          addr_d = advance(addr_q, id_q);
        end
      end
    endcase

    // Status reads are honoured in every state, but a concurrent write always wins.
    if (!wr && rd && cmd) rd_status = 1'b1;

    if (rst) begin
      mem_we    = 1'b0;
      rd_mem    = 1'b0;
      rd_status = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      addr_q  <= 7'h00;
      id_q    <= 1'b1;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      busy    <= (state_d != IDLE);
    end
  end

  // RAM reads see the value before this cycle's write, for both ports.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rst) begin
      rdata     <= 8'h00;
      scan_char <= 8'h00;
    end else begin
      scan_char <= mem[scan_addr];
      if (rd_mem)         rdata <= mem[addr_q];
      else if (rd_status) rdata <= {busy, addr_q};
    end
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Self-checking bench for lcd_char_ctrl: a small reference model feeds a scoreboard
// of expected rdata/scan_char values that are compared one cycle after each access.
module tb_lcd_char_ctrl;

  localparam int COLS        = 16;
  localparam int BUSY_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst, wr, rd, cmd;
  logic [7:0] dbus;
  logic [7:0] rdata;
  logic       busy;
  logic [6:0] scan_addr;
  logic [7:0] scan_char;

  always #5 clk = ~clk;

  lcd_char_ctrl #(.COLS(COLS), .BUSY_CYCLES(BUSY_CYCLES)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .cmd(cmd), .dbus(dbus),
    .rdata(rdata), .busy(busy), .scan_addr(scan_addr), .scan_char(scan_char)
  );

  typedef struct {
    string      tag;
    bit         is_scan;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] m_mem [128];
  logic [6:0] m_addr;
  logic       m_id;
  logic [7:0] m_rdata;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to the next falling edge, drop strobes and retire everything due this cycle.
  task automatic tick();
    exp_t e;
    logic [7:0] act;
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = e.is_scan ? scan_char : rdata;
      checkOutput(e.tag, 32'(act), 32'(e.exp));
    end
  endtask

  task automatic push_exp(input string tag, input bit is_scan, input logic [7:0] v);
    exp_t e;
    e.tag     = tag;
    e.is_scan = is_scan;
    e.exp     = v;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr   = w;
    rd   = r;
    cmd  = c;
    dbus = d;
    tick();
  endtask

  function automatic logic [6:0] m_next(input logic [6:0] a);
    if (m_id) begin
      if (a == 7'(COLS - 1))      return 7'h40;
      if (a == 7'(64 + COLS - 1)) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'(64 + COLS - 1);
    if (a == 7'h40) return 7'(COLS - 1);
    return a - 7'd1;
  endfunction

  function automatic logic [7:0] m_filter(input logic [7:0] d);
    return ((d >= 8'h20) && (d <= 8'h7E)) ? d : 8'h3F;
  endfunction

  task automatic m_blank();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
    m_addr = 7'h00;
    m_id   = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    if (n >= 1000) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_cmd(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, d);
    if (d[7])            m_addr = d[6:0];
    else if (d[6:3] != 0) ;
    else if (d[2])       m_id = d[1];
    else if (d[1])       m_addr = 7'h00;
    else if (d[0]) begin
      m_addr = 7'h00;
      m_id   = 1'b1;
    end
  endtask

  task automatic write_data(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, 1'b0, d);
    m_mem[m_addr] = m_filter(d);
    m_addr        = m_next(m_addr);
  endtask

  task automatic cmd_wait(input logic [7:0] d);
    int n;
    write_cmd(d);
    wait_idle(n);
  endtask

  task automatic data_wait(input logic [7:0] d);
    int n;
    write_data(d);
    wait_idle(n);
  endtask

  task automatic read_status(input string tag, input logic exp_busy);
    wr  = 1'b0;
    rd  = 1'b1;
    cmd = 1'b1;
    m_rdata = {exp_busy, m_addr};
    push_exp(tag, 1'b0, m_rdata);
    tick();
  endtask

  task automatic read_data(input string tag);
    wr  = 1'b0;
    rd  = 1'b1;
    cmd = 1'b0;
    m_rdata = m_mem[m_addr];
    push_exp(tag, 1'b0, m_rdata);
    m_addr = m_next(m_addr);
    tick();
  endtask

  task automatic scan(input string tag, input logic [6:0] a, input logic [7:0] v);
    scan_addr = a;
    push_exp(tag, 1'b1, v);
    tick();
  endtask

  task automatic fill_text();
    for (int i = 0; i < 32; i++) data_wait(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; cmd = 1'b0; dbus = 8'h00; scan_addr = 7'h00;
    m_rdata = 8'h00;
    repeat (3) tick();
    checkOutput("reset_busy", 32'(busy), 32'd1);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_scan", 32'(scan_char), 32'd0);

    // Sweep after release: busy for cycles 0..127.
    m_blank();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    checkOutput("reset_sweep_len", 32'(n), 32'd128);
    for (int a = 0; a < 128; a++) scan("init_scan", 7'(a), 8'h20);
    read_status("init_status", 1'b0);

    // Increment across the row-0 end into row 1.
    write_cmd(8'h8F);
    wait_idle(n);
    checkOutput("hold_len", 32'(n), 32'(BUSY_CYCLES));
    data_wait(8'h41);
    data_wait(8'h42);
    scan("row0_end", 7'h0F, 8'h41);
    scan("row1_start", 7'h40, 8'h42);
    read_status("inc_row0_wrap", 1'b0);

    // Decrement mode, wrap from row 1 start back to row 0 end, character filter.
    cmd_wait(8'h04);
    cmd_wait(8'hC0);
    data_wait(8'h43);
    scan("dec_data", 7'h40, 8'h43);
    read_status("dec_row1_wrap", 1'b0);
    data_wait(8'h07);
    scan("subst", 7'h0F, 8'h3F);
    read_status("dec_step", 1'b0);
    cmd_wait(8'h80);
    data_wait(8'h5A);
    read_status("dec_row0_wrap", 1'b0);
    cmd_wait(8'h06);
    cmd_wait(8'hCF);
    data_wait(8'h7E);
    read_status("inc_row1_wrap", 1'b0);
    scan("tilde", 7'h4F, 8'h7E);

    // No-op command still holds; home resets addr; null command never goes busy.
    write_cmd(8'h48);
    wait_idle(n);
    checkOutput("noop_hold_len", 32'(n), 32'(BUSY_CYCLES));
    cmd_wait(8'h85);
    cmd_wait(8'h02);
    read_status("home", 1'b0);
    write_cmd(8'h00);
    checkOutput("null_cmd_busy", 32'(busy), 32'd0);

    // Status shows busy for exactly BUSY_CYCLES reads after a data write.
    write_data(8'h61);
    for (int i = 0; i < BUSY_CYCLES; i++) read_status("busy_bit", 1'b1);
    read_status("busy_clear", 1'b0);

    // Writes and data reads during HOLD are dropped.
    write_data(8'h62);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h63);
    rd = 1'b1; cmd = 1'b0;
    push_exp("ignored_rd", 1'b0, m_rdata);
    tick();
    wait_idle(n);
    scan("ignored_wr_mem", 7'h02, 8'h20);
    read_status("ignored_wr_addr", 1'b0);

    // Data read-back advances the cursor without going busy.
    cmd_wait(8'h80);
    read_data("data_read0");
    read_data("data_read1");
    checkOutput("read_no_busy", 32'(busy), 32'd0);
    read_status("read_adv", 1'b0);

    // Simultaneous wr and rd: only the write happens.
    wr = 1'b1; rd = 1'b1; cmd = 1'b0; dbus = 8'h55;
    push_exp("wr_rd_same", 1'b0, m_rdata);
    m_mem[m_addr] = 8'h55;
    m_addr = m_next(m_addr);
    tick();
    wait_idle(n);
    scan("wr_rd_mem", 7'h02, 8'h55);

    // Clear with decrement mode active; scan mid-sweep on both sides of the counter.
    cmd_wait(8'h04);
    cmd_wait(8'hCF);
    fill_text();
    write_cmd(8'h01);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 20) begin
        scan_addr = 7'h05;
        push_exp("sweep_low", 1'b1, 8'h20);
      end
      if (n == 21) begin
        scan_addr = 7'h48;
        push_exp("sweep_high", 1'b1, m_mem[7'h48]);
      end
      tick();
    end
    checkOutput("clear_len", 32'(n), 32'd128);
    m_blank();
    scan("after_clear", 7'h48, 8'h20);
    read_status("clear_addr", 1'b0);
    data_wait(8'h41);
    read_status("clear_id", 1'b0);

    // Reset 50 cycles into a clear restarts the sweep from address 0.
    cmd_wait(8'h80);
    fill_text();
    write_cmd(8'h01);
    repeat (50) tick();
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("midclear_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 30) begin
        scan_addr = 7'h48;
        push_exp("restart_high", 1'b1, m_mem[7'h48]);
      end
      tick();
    end
    checkOutput("restart_len", 32'(n), 32'd128);
    m_blank();
    scan("restart_done_hi", 7'h48, 8'h20);
    scan("restart_done_lo", 7'h0F, 8'h20);
    read_status("restart_status", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_char_ctrl.md
# lcd_char_ctrl

Synthesisable, clocked character-display controller: the parametrised successor to the simulation-only LCD model. It holds a 128-byte display RAM with HD44780-style addressing and accepts command and data writes from the CPU I/O strobe. It adds a busy flag, a timed clear sweep, entry-mode direction, row wrap, status and data read-back, and a registered scan port for a display driver.

## Interface
- COLS, 16: visible columns per row (1..64); rows are based at 0x00 and 0x40.
- BUSY_CYCLES, 4: busy hold after an accepted non-clear write (>=1).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  one-cycle write strobe.
- rd  in  1  one-cycle read strobe.
- cmd  in  1  1 = command/status, 0 = data.
- dbus  in  8  write data.
- rdata  out  8  registered read data.
- busy  out  1  controller busy.
- scan_addr  in  7  display-driver read address.
- scan_char  out  8  registered mem[scan_addr].

## Operation
- State: addr[6:0], id (1 = increment), 128x8 RAM, FSM {IDLE, HOLD, CLEAR}, 7-bit counter.
- Reset: while rst=1, state is CLEAR with counter 0, busy=1, addr=0, id=1, rdata=0, scan_char=0. After release, the sweep runs.
- CLEAR: writes 0x20 to mem[counter] each cycle, counter 0..127, then goes to IDLE. busy=1 throughout.
- Command write (wr=1, cmd=1, IDLE only) decodes on the highest set bit of dbus:
  - bit7: addr <= dbus[6:0]; go to HOLD.
  - bits 6..3: no-op; go to HOLD.
  - bit2: id <= dbus[1]; go to HOLD.
  - bit1: addr <= 0; go to HOLD.
  - bit0: addr <= 0, id <= 1; go to CLEAR.
  - dbus=0x00: no-op, no busy.
- Data write (cmd=0, IDLE only): mem[addr] <= dbus if 0x20..0x7E, else 0x3F. Then addr advances and FSM goes to HOLD.
- Advance with id=1:
  - addr==COLS-1 -> 0x40.
  - addr==0x40+COLS-1 -> 0x00.
  - otherwise addr+1 mod 128.
- Advance with id=0:
  - addr==0x00 -> 0x40+COLS-1.
  - addr==0x40 -> COLS-1.
  - otherwise addr-1 mod 128.
- Status read (rd=1, cmd=1): accepted in any state; rdata <= {busy, addr}.
- Data read (rd=1, cmd=0, IDLE only): rdata <= mem[addr], then addr advances as above. No busy.
- Ignored accesses: wr in HOLD/CLEAR; data rd in HOLD/CLEAR. Both leave state and rdata unchanged.
- wr and rd in the same cycle: wr is processed, rd is ignored.
- HOLD: count BUSY_CYCLES cycles, then go to IDLE.

## Timing
- busy is registered. It rises the cycle after an accepted wr and stays high exactly BUSY_CYCLES cycles for non-clear commands, or 128 cycles for clear.
- The next wr is accepted in the first cycle busy=0.
- rdata is valid the cycle after rd and holds until the next accepted read.
- scan_char = mem[scan_addr] one cycle later. On a same-cycle write to the same address it returns the old value (read-before-write).
- Reset asserted mid-HOLD or mid-CLEAR aborts the operation; the sweep restarts from address 0 on release.
- rst released at cycle 0: busy=1 for cycles 0..127, busy=0 at cycle 128, and all RAM is 0x20.

## Test plan
- Reset, wait for busy=0, scan every address -> scan_char=0x20 everywhere; status read returns 0x00.
- Write cmd 0x80|0x0F, wait, write data 0x41 then 0x42 (id=1, COLS=16) -> mem[0x0F]=0x41, mem[0x40]=0x42, addr=0x41.
- Write cmd 0x04 (id=0), cmd 0xC0, data 0x43 -> mem[0x40]=0x43, addr=0x0F. Then data 0x07 -> mem[0x0F]=0x3F.
- Write data, then wr again on the next cycle with busy=1 -> second write ignored; status read shows bit7=1 for BUSY_CYCLES cycles.
- Fill text, write cmd 0x01 -> busy for exactly 128 cycles; scan mid-sweep shows 0x20 below the counter and old data above it; afterwards addr=0, id=1.
- Assert rst 50 cycles into a clear -> sweep restarts from 0; busy=0 exactly 128 cycles after release.
